gauss_seq: RTL and testbench

GAUSS_SEQ -- requirements
Module: gauss_seq

---
 rtl/gauss_seq_if.sv | 31 +++
 rtl/gauss_seq.sv | 128 ++++++++++++
 tb/tb_gauss_seq.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gauss_seq_if.sv
// Bundle of all gauss_seq handshakes: control, PRNG fetch, sampler issue/return, coefficient RAM write.
// start is a one-cycle pulse; rnd_req/rnd_ack is a req/ack pair whose data is valid with ack; r_valid and val_valid are single-cycle pulses with no back-pressure.
interface gauss_seq_if;
  logic                start;
  logic [3:0]          logn;
  logic                busy;
  logic                done;
  logic [15:0]         rej_cnt;
  logic                rnd_req;
  logic                rnd_ack;
  logic [63:0]         rnd_r1;
  logic [63:0]         rnd_r2;
  logic                r_valid;
  logic [63:0]         r1;
  logic [63:0]         r2;
  logic                val_valid;
  logic signed [31:0]  val;
  logic                wr_en;
  logic [9:0]          wr_addr;
  logic signed [7:0]   wr_data;

  modport master (
    output start, logn, rnd_ack, rnd_r1, rnd_r2, val_valid, val,
    input  busy, done, rej_cnt, rnd_req, r_valid, r1, r2, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  start, logn, rnd_ack, rnd_r1, rnd_r2, val_valid, val,
    output busy, done, rej_cnt, rnd_req, r_valid, r1, r2, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/gauss_seq.sv
// Sequencer that draws Gaussian samples one at a time and writes n = 2^logn small
// coefficients to RAM, rejecting out-of-range samples and forcing an odd coefficient sum.
module gauss_seq (
  input  logic            clk,
  input  logic            rst,
  gauss_seq_if.slave      bus,
  output logic [2:0]      dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  last_q, last_d;
  logic [9:0]  idx_q, idx_d;
  logic        par_q, par_d;
  logic [15:0] rej_q, rej_d;
  logic [63:0] w1_q, w1_d;
  logic [63:0] w2_q, w2_d;
  logic        wr_en_q, wr_en_d;
  logic [9:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;

  logic [3:0]  lg;
  logic        in_range;
  logic        parity_bad;
  logic        reject;

  assign lg         = (bus.logn > 4'd10) ? 4'd10 : bus.logn;
  assign in_range   = (bus.val >= -32'sd127) && (bus.val <= 32'sd127);
  // Last coefficient must make the running sum odd.
  assign parity_bad = (idx_q == last_q) && !(par_q ^ bus.val[0]);
  assign reject     = !in_range || parity_bad;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    idx_d     = idx_q;
    par_d     = par_q;
    rej_d     = rej_q;
    w1_d      = w1_q;
    w2_d      = w2_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          last_d  = ~(10'h3FF << lg);
          idx_d   = 10'd0;
          par_d   = 1'b0;
          rej_d   = 16'd0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus.rnd_ack) begin
          w1_d    = bus.rnd_r1;
          w2_d    = bus.rnd_r2;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.val_valid) begin
          if (reject) begin
            rej_d   = (rej_q == 16'hFFFF) ? rej_q : rej_q + 16'd1;
            state_d = S_FETCH;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = idx_q;
            wr_data_d = bus.val[7:0];
            par_d     = par_q ^ bus.val[0];
            idx_d     = idx_q + 10'd1;
            state_d   = (idx_q == last_q) ? S_DONE : S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_q    <= 10'd0;
      idx_q     <= 10'd0;
      par_q     <= 1'b0;
      rej_q     <= 16'd0;
      w1_q      <= 64'd0;
      w2_q      <= 64'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 10'd0;
      wr_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      idx_q     <= idx_d;
      par_q     <= par_d;
      rej_q     <= rej_d;
      w1_q      <= w1_d;
      w2_q      <= w2_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // The latched words only change on entry to ISSUE, so r1/r2 hold the last issue elsewhere.
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_DONE);
  assign bus.rnd_req = (state_q == S_FETCH);
  assign bus.r_valid = (state_q == S_ISSUE);
  assign bus.r1      = w1_q;
  assign bus.r2      = w2_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.rej_cnt = rej_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gauss_seq.sv
// Directed bench for gauss_seq: PRNG and sampler responders, write scoreboard, summary report.
module tb_gauss_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;

  gauss_seq_if bus ();

  gauss_seq dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  int            tests = 0;
  int            fails = 0;
  logic [17:0]   exp_q[$];
  logic [127:0]  rnd_q[$];
  int            samp_q[$];
  bit            prng_stall = 1'b0;
  int            wr_cnt = 0;
  int            done_cnt = 0;
  logic [63:0]   last_r1 = 64'd0;
  logic [63:0]   last_r2 = 64'd0;
  bit            pend = 1'b0;
  int            lat = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_wr(input int a, input int d);
    exp_q.push_back({a[9:0], d[7:0]});
  endtask

  // PRNG: acknowledges a request in the same cycle unless stalled.
  always @(negedge clk) begin
    logic [63:0] a, b;
    bus.rnd_ack = 1'b0;
    if (bus.rnd_req && !prng_stall && !rst) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      bus.rnd_r1  = a;
      bus.rnd_r2  = b;
      bus.rnd_ack = 1'b1;
      rnd_q.push_back({a, b});
    end
  end

  // Sampler: answers each issue after 1..3 cycles using the next queued value.
  always @(negedge clk) begin
    logic [127:0] w;
    bus.val_valid = 1'b0;
    if (pend && samp_q.size() > 0) begin
      if (lat > 0) lat--;
      else begin
        bus.val_valid = 1'b1;
        bus.val       = samp_q.pop_front();
        pend          = 1'b0;
      end
    end
    if (bus.r_valid) begin
      if (rnd_q.size() == 0) check("issue_unexpected", {63'd0, bus.r_valid}, 64'd0);
      else begin
        w = rnd_q.pop_front();
        check("issue_r1", bus.r1, w[127:64]);
        check("issue_r2", bus.r2, w[63:0]);
        last_r1 = w[127:64];
        last_r2 = w[63:0];
      end
      pend = 1'b1;
      lat  = $urandom_range(0, 2);
    end
  end

  // Write scoreboard and done counter.
  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (bus.wr_en) begin
      wr_cnt++;
      if (exp_q.size() == 0) check("wr_unexpected", {63'd0, bus.wr_en}, 64'd0);
      else check("wr_addr_data", {46'd0, bus.wr_addr, bus.wr_data}, {46'd0, exp_q.pop_front()});
    end
  end

  task automatic start_run(input logic [3:0] lg);
    bus.logn  = lg;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic finish_run(input string tag, input int d0, input int budget, input logic [15:0] exp_rej);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
    check({tag, "_rej_cnt"}, {48'd0, bus.rej_cnt}, {48'd0, exp_rej});
    check({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_idle"}, {61'd0, bus.busy, bus.done, bus.wr_en}, 64'd0);
    check({tag, "_r1_hold"}, bus.r1, last_r1);
    check({tag, "_r2_hold"}, bus.r2, last_r2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, base, n, par, v, exp_rej;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.logn  = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {59'd0, bus.busy, bus.done, bus.rnd_req, bus.r_valid, bus.wr_en}, 64'd0);
    check("rst_r1", bus.r1, 64'd0);
    check("rst_r2", bus.r2, 64'd0);
    check("rst_wr", {46'd0, bus.wr_addr, bus.wr_data}, 64'd0);
    check("rst_rej", {48'd0, bus.rej_cnt}, 64'd0);
    check("rst_state", {61'd0, dbg_state}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // logn=3, small values, no rejects
    foreach (samp_q[i]) samp_q.delete();
    samp_q = '{1, 0, 0, 0, 0, 0, 0, 2};
    exp_wr(0, 1);
    for (int i = 1; i < 7; i++) exp_wr(i, 0);
    exp_wr(7, 2);
    d0 = done_cnt;
    start_run(4'd3);
    check("t031_busy", {63'd0, bus.busy}, 64'd1);
    check("t031_fetch", {61'd0, dbg_state}, 64'd1);
    finish_run("t031", d0, 300, 16'd0);

    // range boundaries: 200 and -128 rejected, +-127 accepted
    samp_q = '{200, -128, 5, -127, 127, 4};
    exp_wr(0, 5);
    exp_wr(1, 8'h81);
    exp_wr(2, 8'h7F);
    exp_wr(3, 4);
    d0 = done_cnt;
    start_run(4'd2);
    finish_run("t032", d0, 300, 16'd2);

    // logn=1: last coefficient must give an odd sum (1+3, 1+5 rejected)
    samp_q = '{1, 3, 5, 4};
    exp_wr(0, 1);
    exp_wr(1, 4);
    d0 = done_cnt;
    start_run(4'd1);
    finish_run("t033", d0, 300, 16'd2);

    // PRNG stall for 10 cycles, start pulsed mid-run with a different logn
    samp_q = '{2, 3, 4, 5, 6};
    exp_wr(0, 2);
    exp_wr(1, 3);
    exp_wr(2, 4);
    exp_wr(3, 6);
    prng_stall = 1'b1;
    d0 = done_cnt;
    start_run(4'd2);
    for (int i = 0; i < 10; i++) begin
      check("t034_stall", {62'd0, bus.rnd_req, bus.r_valid}, 64'd2);
      if (i == 4) begin
        bus.logn  = 4'd0;
        bus.start = 1'b1;
      end
      if (i == 5) bus.start = 1'b0;
      @(negedge clk);
    end
    prng_stall = 1'b0;
    finish_run("t034", d0, 300, 16'd1);

    // reset while waiting on the sampler at idx=5
    samp_q = '{1, 2, 3, 4, 5};
    for (int i = 0; i < 5; i++) exp_wr(i, i + 1);
    d0   = done_cnt;
    base = wr_cnt;
    start_run(4'd3);
    n = 0;
    while (!(wr_cnt - base == 5 && dbg_state == 3'd3) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t035_reached_wait", {61'd0, dbg_state}, 64'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t035_busy", {63'd0, bus.busy}, 64'd0);
    check("t035_state", {61'd0, dbg_state}, 64'd0);
    check("t035_rej", {48'd0, bus.rej_cnt}, 64'd0);
    check("t035_r1", bus.r1, 64'd0);
    rnd_q.delete();
    samp_q.push_back(9);
    repeat (6) @(negedge clk);
    check("t035_no_late_write", 64'(wr_cnt - base), 64'd5);
    check("t035_no_done", 64'(done_cnt - d0), 64'd0);
    check("t035_pending_left", 64'(exp_q.size()), 64'd0);
    last_r1 = 64'd0;
    last_r2 = 64'd0;
    samp_q = '{2, 7};
    exp_wr(0, 7);
    d0 = done_cnt;
    start_run(4'd0);
    finish_run("t035_restart", d0, 300, 16'd1);

    // logn=15 clamps to 1024 coefficients
    samp_q.delete();
    par     = 0;
    exp_rej = 0;
    for (int i = 0; i < 1023; i++) begin
      if (i % 97 == 0) begin
        samp_q.push_back((i % 2 == 0) ? 128 : -200);
        exp_rej++;
      end
      v = int'($urandom_range(0, 254)) - 127;
      samp_q.push_back(v);
      exp_wr(i, v);
      par = par ^ (v & 1);
    end
    samp_q.push_back(10 + par);
    exp_rej++;
    v = 20 + (1 - par);
    samp_q.push_back(v);
    exp_wr(1023, v);
    d0   = done_cnt;
    base = wr_cnt;
    start_run(4'd15);
    finish_run("t036", d0, 12000, exp_rej[15:0]);
    check("t036_writes", 64'(wr_cnt - base), 64'd1024);
    check("t036_last_addr", {54'd0, bus.wr_addr}, 64'd1023);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
